// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its command FIFO.
// Optional feature macro used by the top: ALU_STICKY_FLAGS_EN.
package alu_pkg;

  localparam int DATA_W    = 32;
  localparam int OP_W      = 4;
  localparam int FLAG_W    = 3;
  localparam int OP_MAX    = 5;
  // Tag storage width inside the command struct; the top's TAG_W must not exceed it.
  localparam int TAG_MAX_W = 16;

  localparam int FLG_ZERO  = 0;
  localparam int FLG_OVF   = 1;
  localparam int FLG_CARRY = 2;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SHL = 4'd5
  } alu_op_e;

  // op stays a raw vector so illegal encodings survive the queue and can be flagged.
  typedef struct packed {
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [OP_W-1:0]      op;
    logic [TAG_MAX_W-1:0] tag;
  } alu_cmd_t;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_W'(OP_MAX));
  endfunction

endpackage

// File: rtl/alu_issue_stage_fifo.sv
// Synchronous command FIFO of alu_cmd_t with push/pop, empty and occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  alu_cmd_t      push_data,
  input  logic          pop,
  output alu_cmd_t      head,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;
  alu_cmd_t      mem_q [DEPTH];

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only observed once count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_issue_stage.sv
// Command queue and registered result stage wrapped around an external combinational ALU.
// Optional macro ALU_STICKY_FLAGS_EN adds clr_sticky / sticky_flags accumulation.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // Both interfaces: a transfer happens on a rising edge where valid && ready;
  // valid, once raised, keeps its payload stable until that transfer.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_ovf,
  input  logic              alu_carry,
`ifdef ALU_STICKY_FLAGS_EN
  input  logic              clr_sticky,
  output logic [1:0]        sticky_flags,
`endif
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [FLAG_W-1:0] res_flags,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  alu_cmd_t      push_cmd;
  alu_cmd_t      head;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          push;
  logic          load;
  logic          head_legal;
  logic          unused_tag;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic [FLAG_W-1:0] res_flags_q, res_flags_d;
  logic [TAG_W-1:0]  res_tag_q,   res_tag_d;
  logic              res_err_q,   res_err_d;

  assign cmd_ready = (fifo_count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;

  always_comb begin
    push_cmd     = '0;
    push_cmd.a   = cmd_a;
    push_cmd.b   = cmd_b;
    push_cmd.op  = cmd_op;
    push_cmd.tag = TAG_MAX_W'(cmd_tag);
  end

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_cmd),
    .pop       (load),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // The ALU sees zeros rather than stale storage whenever nothing is queued.
  assign alu_a      = fifo_empty ? '0 : head.a;
  assign alu_b      = fifo_empty ? '0 : head.b;
  assign alu_opcode = fifo_empty ? '0 : head.op;

  assign head_legal = op_is_legal(head.op);
  assign load       = !fifo_empty && (!res_valid_q || res_ready);
  assign unused_tag = ^head.tag;

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_tag_d   = res_tag_q;
    res_err_d   = res_err_q;
    if (load) begin
      res_valid_d = 1'b1;
      res_tag_d   = head.tag[TAG_W-1:0];
      res_err_d   = !head_legal;
      res_data_d  = '0;
      res_flags_d = '0;
      // ALU output is undefined for illegal opcodes, so publish clean zeros instead.
      if (head_legal) begin
        res_data_d             = alu_result;
        res_flags_d[FLG_ZERO]  = alu_zero;
        res_flags_d[FLG_OVF]   = alu_ovf;
        res_flags_d[FLG_CARRY] = alu_carry;
      end
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_tag_q   <= '0;
      res_err_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_tag_q   <= res_tag_d;
      res_err_q   <= res_err_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_tag   = res_tag_q;
  assign res_err   = res_err_q;

`ifdef ALU_STICKY_FLAGS_EN
  logic [1:0] sticky_q, sticky_d;
  logic [1:0] new_sticky;

  assign new_sticky = {alu_carry, alu_ovf};

  // A clear landing on the same edge as a legal load keeps that load's flags.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky) sticky_d = '0;
    if (load && head_legal) sticky_d = sticky_d | new_sticky;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Command buffer and result register around the team's combinational 32-bit ALU. The ALU itself is instantiated outside this block.
- Accepts tagged ALU commands over a valid/ready interface and queues them in a FIFO.
- Drives the FIFO head onto the ALU operand/opcode inputs, then captures result and flags into a registered valid/ready output for writeback.
- Sits directly upstream of the ALU and holds its output pipeline register.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, minimum 2.
- TAG_W, 4, width of the tag carried from command to result.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept this cycle.
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_op  in  4  ALU opcode: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl.
- cmd_tag  in  TAG_W  command tag.
- alu_a  out  32  to ALU A; FIFO head operand.
- alu_b  out  32  to ALU B.
- alu_opcode  out  4  to ALU opcode.
- alu_result  in  32  from ALU, combinational same cycle.
- alu_zero  in  1  ALU zero flag.
- alu_ovf  in  1  ALU overflow flag.
- alu_carry  in  1  ALU carry-out flag.
- res_valid  out  1  result register holds data.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  registered result.
- res_flags  out  3  {carry, ovf, zero}.
- res_tag  out  TAG_W  tag of the result.
- res_err  out  1  opcode was illegal (6..15).

Behaviour:
- Reset (async assert, sync deassert by design): FIFO empty, pointers 0, count 0.
  - res_valid, res_data, res_flags, res_tag and res_err are all 0.
  - alu_a, alu_b and alu_opcode are 0 while empty.
- cmd_ready = (count != DEPTH).
  - A push occurs when cmd_valid && cmd_ready.
  - A push while full is impossible; no push-through-when-full.
- alu_* outputs are driven combinationally from the FIFO head entry. When the FIFO is empty they are driven to 0.
- load = !empty && (!res_valid || res_ready). On load:
  - Pop the head.
  - Register res_data and res_flags from the ALU, and res_tag from the head.
  - Set res_err = (head op > 5).
  - Set res_valid = 1.
- If res_valid && res_ready && empty: res_valid goes to 0, and the other res_* registers hold their values.
- Illegal opcode: res_data is forced to 0 and res_flags to 0, because the ALU output is undefined in this case. res_err = 1.
- Latency: a command accepted in cycle N appears with res_valid = 1 in cycle N+2 when the FIFO is empty and the output is free.
- Throughput: 1 result per cycle when res_ready is held at 1.
- Backpressure: while res_valid && !res_ready, the res_* outputs are stable and the FIFO does not pop.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.
- Commands are processed strictly in order. The tag is passed through unmodified.
- Reset asserted mid-operation: all queued commands and any pending result are discarded immediately. No partial output.

Optional Feature:
- Macro: ALU_STICKY_FLAGS_EN.
- When defined, the block adds two ports:
  - clr_sticky, input, 1 bit.
  - sticky_flags, output, 2 bits, {carry, ovf}.
- sticky_flags ORs in the carry and ovf bits of every loaded, legal result.
- clr_sticky clears sticky_flags on the next edge. If clr_sticky coincides with a load, the new flags win, so the result is set rather than cleared.
- Reset value of sticky_flags is 0.
- When not defined: neither port exists and there is no sticky logic. All other behaviour is identical.

Decomposition:
- alu_pkg holds:
  - localparam DATA_W = 32.
  - Opcode enum alu_op_e: ADD, SUB, AND, OR, XOR, SHL.
  - localparam OP_MAX = 5.
  - Flag bit indices FLG_ZERO = 0, FLG_OVF = 1, FLG_CARRY = 2.
  - Packed struct alu_cmd_t {a, b, op, tag}.
- One sub-module, alu_cmd_fifo, is natural: a parameterised synchronous FIFO of alu_cmd_t with push/pop, full/empty and count.
- alu_issue_stage instantiates alu_cmd_fifo. The output register and the sticky logic live in the top.

Test Plan:
- Single command a=5, b=3, op=0, tag=2 with res_ready=1: res_valid rises 2 cycles after acceptance with res_data=8, flags=000, tag=2.
- Back-to-back push of 4 cmds (sub 7-7, and F0&0F, or, xor) with res_ready=1: 4 consecutive results; the first has data 0 and zero=1, and tags come out in order.
- res_ready=0, push 5 cmds with DEPTH=4: 1 result is held in the output register, the FIFO fills to 4, and cmd_ready drops after the 5th acceptance. Release res_ready: all 5 drain in order.
- op=9, a=1, b=1: res_err=1, res_data=0, res_flags=000.
- Assert rst_n=0 mid-drain with 3 queued: res_valid=0 and cmd_ready=1 immediately. No stale results appear after release.
- ALU_STICKY_FLAGS_EN: add FFFFFFFF+1 sets sticky carry. A following add 1+1 keeps it set. clr_sticky clears it to 00.
